// File: rtl/rgb_layer_mixer_pkg.sv
// Shared constants for the RGB layer mixer: colour defaults, named colours and collision counter helpers.
package rgb_layer_mixer_pkg;

  localparam int unsigned RGB_W_DEF  = 8;
  localparam int unsigned COLL_CNT_W = 16;

  localparam logic [7:0] BLACK  = 8'h00;
  localparam logic [7:0] WHITE  = 8'hFF;
  localparam logic [7:0] BASKET = 8'hA4;

  localparam logic [7:0] BG_COLOR_DEF = WHITE;

  // Saturating increment for the per-frame collision accumulator
  function automatic logic [COLL_CNT_W-1:0] sat_inc(input logic [COLL_CNT_W-1:0] v);
    return (&v) ? v : v + COLL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rgb_layer_mixer_layer_prio_sel.sv
// Combinational priority selector: the lowest-index effective layer supplies the colour.
module layer_prio_sel #(
  parameter int unsigned N_LAYERS = 4,
  parameter int unsigned RGB_W    = 8
) (
  input  logic [N_LAYERS-1:0]       eff,
  input  logic [N_LAYERS*RGB_W-1:0] layer_color,
  output logic [RGB_W-1:0]          color_c,
  output logic                      any_hit_c
);

  always_comb begin
    color_c   = '0;
    any_hit_c = 1'b0;
    for (int i = 0; i < int'(N_LAYERS); i++) begin
      if (eff[i] && !any_hit_c) begin
        color_c   = layer_color[i*RGB_W +: RGB_W];
        any_hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_layer_mixer.sv
// Two-stage sprite layer mixer with background colour, blanking and per-layer blinking.
// Optional collision statistics on layers 0/1 when RGB_MIXER_COLLISION_EN is defined.
module rgb_layer_mixer
  import rgb_layer_mixer_pkg::*;
#(
  parameter int unsigned      N_LAYERS   = 4,
  parameter int unsigned      RGB_W      = RGB_W_DEF,
  parameter logic [RGB_W-1:0] BG_COLOR   = RGB_W'(BG_COLOR_DEF),
  parameter int unsigned      BLINK_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_on,
  input  logic                      frame_tick,
  input  logic [N_LAYERS-1:0]       layer_hit,
  input  logic [N_LAYERS*RGB_W-1:0] layer_color,
  input  logic [N_LAYERS-1:0]       blink_mask,
  input  logic [N_LAYERS-1:0]       layer_en,
  output logic [RGB_W-1:0]          rgb_out,
  output logic                      video_on_q
`ifdef RGB_MIXER_COLLISION_EN
  ,
  output logic                      collision,
  output logic [COLL_CNT_W-1:0]     collision_cnt
`endif
);

  logic [BLINK_LOG2-1:0] blink_cnt;
  logic                  blink_phase;
  logic [N_LAYERS-1:0]   eff;
  logic [RGB_W-1:0]      sel_color;
  logic                  any_hit;
  logic [RGB_W-1:0]      s1_color;
  logic                  s1_video;

  assign eff = layer_hit & layer_en & (~blink_mask | {N_LAYERS{blink_phase}});

  layer_prio_sel #(
    .N_LAYERS (N_LAYERS),
    .RGB_W    (RGB_W)
  ) u_prio (
    .eff         (eff),
    .layer_color (layer_color),
    .color_c     (sel_color),
    .any_hit_c   (any_hit)
  );

  // Frame counter; phase flips on each wrap, so the current pixel still sees the old phase
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_tick) begin
      blink_cnt <= blink_cnt + BLINK_LOG2'(1);
      if (&blink_cnt) blink_phase <= ~blink_phase;
    end
  end

  // Stage 1: colour selection registered alongside video_on
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_color <= '0;
      s1_video <= 1'b0;
    end else begin
      s1_color <= any_hit ? sel_color : BG_COLOR;
      s1_video <= video_on;
    end
  end

  // Stage 2: blanking applied to the selected colour
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out    <= '0;
      video_on_q <= 1'b0;
    end else begin
      rgb_out    <= s1_video ? s1_color : '0;
      video_on_q <= s1_video;
    end
  end

`ifdef RGB_MIXER_COLLISION_EN
  logic                  coll;
  logic [COLL_CNT_W-1:0] coll_acc;

  assign coll = eff[0] & eff[1] & video_on;

  // A collision coinciding with frame_tick belongs to the new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      coll_acc      <= '0;
      collision_cnt <= '0;
      collision     <= 1'b0;
    end else if (frame_tick) begin
      collision_cnt <= coll_acc;
      coll_acc      <= coll ? COLL_CNT_W'(1) : '0;
      collision     <= coll;
    end else if (coll) begin
      coll_acc  <= sat_inc(coll_acc);
      collision <= 1'b1;
    end
  end
`endif

endmodule
